// File: rtl/sync_fifo_param.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_param
// Brief    : Parametrised single-clock FIFO with count, almost flags, flush and
//            overflow/underflow pulses. All outputs registered.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] c_depth    = DEPTH[AW:0];
  localparam logic [AW:0] c_af_level = AF_LEVEL[AW:0];
  localparam logic [AW:0] c_ae_level = AE_LEVEL[AW:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [AW:0]           w_count_nxt;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign w_rd_acc = read_en && !r_empty && !flush;
  assign w_wr_acc = write_en && (!r_full || w_rd_acc) && !flush;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_data_out     <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
      end
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == c_depth);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= c_af_level);
      r_almost_empty <= (w_count_nxt <= c_ae_level);
      r_overflow     <= write_en && !w_wr_acc;
      r_underflow    <= read_en && !w_rd_acc;
    end
  end

  assign data_out     = r_data_out;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
//------------------------------------------------------------------------------
// Module   : tb_sync_fifo_param
// Brief    : Directed self-checking bench for sync_fifo_param (DEPTH=8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          write_en;
  logic [DW-1:0] data_in;
  logic          read_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  int tests_run    = 0;
  int tests_failed = 0;

  sync_fifo_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP),
    .AF_LEVEL  (6),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .write_en    (write_en),
    .data_in     (data_in),
    .read_en     (read_en),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0;
    read_en  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    data_in = '0;
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({empty, full, count, data_out, overflow, underflow, almost_empty, almost_full}
        !== {1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: empty=%b full=%b count=%0d dout=%h ovf=%b unf=%b ae=%b af=%b",
               empty, full, count, data_out, overflow, underflow, almost_empty, almost_full);
    end
    step();
    step();
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_fill_overflow_drain();
    for (int i = 0; i < 8; i++) begin
      write_en = 1'b1;
      data_in  = 8'(i);
      step();
      tests_run++;
      if ({count, almost_full, full} !== {4'(i + 1), (i + 1 >= 6), (i + 1 == 8)}) begin
        tests_failed++;
        $display("FAIL fill[%0d]: count=%0d af=%b full=%b want count=%0d af=%b full=%b",
                 i, count, almost_full, full, i + 1, (i + 1 >= 6), (i + 1 == 8));
      end
    end
    data_in = 8'hAA;
    step();
    tests_run++;
    if ({overflow, count, full} !== {1'b1, 4'd8, 1'b1}) begin
      tests_failed++;
      $display("FAIL overflow: ovf=%b count=%0d full=%b want 1/8/1", overflow, count, full);
    end
    idle();
    step();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_pulse: ovf=%b want 0", overflow);
    end
    for (int i = 0; i < 8; i++) begin
      read_en = 1'b1;
      step();
      tests_run++;
      if ({data_out, count, almost_empty} !== {8'(i), 4'(7 - i), (7 - i <= 2)}) begin
        tests_failed++;
        $display("FAIL drain[%0d]: dout=%h count=%0d ae=%b want %h/%0d/%b",
                 i, data_out, count, almost_empty, 8'(i), 7 - i, (7 - i <= 2));
      end
    end
    idle();
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_empty: empty=%b want 1", empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      write_en = 1'b1;
      data_in  = 8'hA0 + 8'(i);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      read_en = 1'b1;
      step();
    end
    idle();
    tests_run++;
    if ({data_out, empty} !== {8'hA4, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_pre: dout=%h empty=%b want a4/1", data_out, empty);
    end
    for (int i = 0; i < 8; i++) begin
      write_en = 1'b1;
      data_in  = 8'h10 + 8'(i);
      step();
    end
    idle();
    tests_run++;
    if ({full, empty, count} !== {1'b1, 1'b0, 4'd8}) begin
      tests_failed++;
      $display("FAIL wrap_full: full=%b empty=%b count=%0d want 1/0/8", full, empty, count);
    end
    for (int i = 0; i < 8; i++) begin
      read_en = 1'b1;
      step();
      tests_run++;
      if (data_out !== 8'h10 + 8'(i)) begin
        tests_failed++;
        $display("FAIL wrap_read[%0d]: dout=%h want %h", i, data_out, 8'h10 + 8'(i));
      end
    end
    idle();
    tests_run++;
    if ({full, empty, count} !== {1'b0, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("FAIL wrap_empty: full=%b empty=%b count=%0d want 0/1/0", full, empty, count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      write_en = 1'b1;
      data_in  = 8'h20 + 8'(i);
      step();
    end
    data_in = 8'h55;
    read_en = 1'b1;
    step();
    tests_run++;
    if ({count, overflow, full, data_out} !== {4'd8, 1'b0, 1'b1, 8'h20}) begin
      tests_failed++;
      $display("FAIL simul_full: count=%0d ovf=%b full=%b dout=%h want 8/0/1/20",
               count, overflow, full, data_out);
    end
    write_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      tests_run++;
      if (data_out !== 8'h20 + 8'(i)) begin
        tests_failed++;
        $display("FAIL simul_read[%0d]: dout=%h want %h", i, data_out, 8'h20 + 8'(i));
      end
    end
    step();
    tests_run++;
    if ({data_out, empty} !== {8'h55, 1'b1}) begin
      tests_failed++;
      $display("FAIL simul_last: dout=%h empty=%b want 55/1", data_out, empty);
    end
    write_en = 1'b1;
    data_in  = 8'h33;
    step();
    tests_run++;
    if ({underflow, count, data_out, empty} !== {1'b1, 4'd1, 8'h55, 1'b0}) begin
      tests_failed++;
      $display("FAIL simul_empty: unf=%b count=%0d dout=%h empty=%b want 1/1/55/0",
               underflow, count, data_out, empty);
    end
    write_en = 1'b0;
    step();
    tests_run++;
    if ({data_out, count, underflow} !== {8'h33, 4'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL simul_next: dout=%h count=%0d unf=%b want 33/0/0", data_out, count, underflow);
    end
    idle();
  endtask

  task automatic test_underflow();
    read_en = 1'b1;
    step();
    tests_run++;
    if ({underflow, data_out, count} !== {1'b1, 8'h33, 4'd0}) begin
      tests_failed++;
      $display("FAIL underflow: unf=%b dout=%h count=%0d want 1/33/0", underflow, data_out, count);
    end
    idle();
    step();
    tests_run++;
    if (underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_pulse: unf=%b want 0", underflow);
    end
  endtask

  task automatic test_flush_and_async_reset();
    for (int i = 0; i < 5; i++) begin
      write_en = 1'b1;
      data_in  = 8'h40 + 8'(i);
      step();
    end
    read_en = 1'b1;
    flush   = 1'b1;
    data_in = 8'hEE;
    step();
    tests_run++;
    if ({count, empty, full, overflow, underflow, data_out} !==
        {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33}) begin
      tests_failed++;
      $display("FAIL flush: count=%0d empty=%b full=%b ovf=%b unf=%b dout=%h want 0/1/0/0/0/33",
               count, empty, full, overflow, underflow, data_out);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      write_en = 1'b1;
      data_in  = 8'h60 + 8'(i);
      step();
    end
    read_en = 1'b1;
    step();
    tests_run++;
    if ({data_out, count} !== {8'h60, 4'd3}) begin
      tests_failed++;
      $display("FAIL post_flush: dout=%h count=%0d want 60/3", data_out, count);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({count, empty, full, data_out, almost_empty} !== {4'd0, 1'b1, 1'b0, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL async_reset: count=%0d empty=%b full=%b dout=%h ae=%b want 0/1/0/00/1",
               count, empty, full, data_out, almost_empty);
    end
    idle();
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_overflow_drain();
    test_wrap();
    test_back_to_back();
    test_underflow();
    test_flush_and_async_reset();
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
